// File: rtl/wvb_rd_ctrl.sv
// Waveform buffer read controller: pops event headers, streams each event's samples
// from the buffer RAM through a small skid FIFO, and advances rd_ptr once an event is consumed.
module wvb_rd_ctrl #(
    parameter int P_DATA_WIDTH     = 22,
    parameter int P_ADR_WIDTH      = 12,
    parameter int P_LTC_WIDTH      = 48,
    parameter int P_PRE_CONF_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hdr_empty,
    output logic                        hdr_rdreq,
    input  logic [P_ADR_WIDTH-1:0]      hdr_start_addr,
    input  logic [P_ADR_WIDTH-1:0]      hdr_stop_addr,
    input  logic [P_LTC_WIDTH-1:0]      hdr_evt_ltc,
    input  logic [1:0]                  hdr_trig_src,
    input  logic                        hdr_cnst_run,
    input  logic [P_PRE_CONF_WIDTH-1:0] hdr_pre_conf,
    output logic [P_ADR_WIDTH-1:0]      wvb_rd_addr,
    input  logic [P_DATA_WIDTH-1:0]     wvb_rd_data,
    output logic [P_DATA_WIDTH-1:0]     out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sof,
    output logic                        out_eof,
    output logic [P_ADR_WIDTH:0]        out_evt_len,
    output logic [P_LTC_WIDTH-1:0]      out_evt_ltc,
    output logic [1:0]                  out_trig_src,
    output logic                        out_cnst_run,
    output logic [P_PRE_CONF_WIDTH-1:0] out_pre_conf,
    output logic [P_ADR_WIDTH-1:0]      rd_ptr,
    output logic                        busy
);
    localparam int LP_DEPTH = 4;
    localparam logic [P_ADR_WIDTH-1:0] LP_ADR_ONE = {{(P_ADR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [P_ADR_WIDTH:0]   LP_LEN_ONE = {{P_ADR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_HDR_POP, S_HDR_LATCH, S_DATA, S_DRAIN} t_state;

    t_state                      r_state;
    logic [P_ADR_WIDTH-1:0]      r_addr;
    logic [P_ADR_WIDTH-1:0]      r_stop;
    logic [P_ADR_WIDTH-1:0]      r_rd_ptr;
    logic [P_ADR_WIDTH:0]        r_evt_len;
    logic [P_ADR_WIDTH:0]        r_remain;
    logic [P_LTC_WIDTH-1:0]      r_evt_ltc;
    logic [1:0]                  r_trig_src;
    logic                        r_cnst_run;
    logic [P_PRE_CONF_WIDTH-1:0] r_pre_conf;
    logic                        r_rd_vld;
    logic                        r_rd_sof;
    logic                        r_rd_eof;

    logic [P_DATA_WIDTH-1:0]     r_fifo_data [LP_DEPTH];
    logic                        r_fifo_sof  [LP_DEPTH];
    logic                        r_fifo_eof  [LP_DEPTH];
    logic [1:0]                  r_head;
    logic [1:0]                  r_tail;
    logic [2:0]                  r_count;

    logic w_push;
    logic w_pop;
    logic w_issue;
    logic w_last_pop;

    // A read is only issued when the FIFO can absorb it even if the consumer stalls.
    assign w_push     = r_rd_vld;
    assign w_pop      = (r_count != 3'd0) && out_ready;
    assign w_issue    = (r_state == S_DATA) && ((r_count + {2'b00, r_rd_vld}) < 3'd4);
    assign w_last_pop = w_pop && r_fifo_eof[r_head];

    generate
        for (genvar gi = 0; gi < LP_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_fifo_data[gi] <= '0;
                    r_fifo_sof[gi]  <= 1'b0;
                    r_fifo_eof[gi]  <= 1'b0;
                end else if (w_push && (r_tail == 2'(gi))) begin
                    r_fifo_data[gi] <= wvb_rd_data;
                    r_fifo_sof[gi]  <= r_rd_sof;
                    r_fifo_eof[gi]  <= r_rd_eof;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) r_tail <= r_tail + 2'd1;
            if (w_pop)  r_head <= r_head + 2'd1;
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_stop     <= '0;
            r_rd_ptr   <= '0;
            r_evt_len  <= '0;
            r_remain   <= '0;
            r_evt_ltc  <= '0;
            r_trig_src <= '0;
            r_cnst_run <= 1'b0;
            r_pre_conf <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_sof   <= 1'b0;
            r_rd_eof   <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            r_rd_sof <= (r_remain == r_evt_len);
            r_rd_eof <= (r_remain == LP_LEN_ONE);
            case (r_state)
                S_IDLE: begin
                    if (!hdr_empty) r_state <= S_HDR_POP;
                end
                S_HDR_POP: begin
                    r_state <= S_HDR_LATCH;
                end
                S_HDR_LATCH: begin
                    r_evt_len  <= {1'b0, hdr_stop_addr - hdr_start_addr} + LP_LEN_ONE;
                    r_remain   <= {1'b0, hdr_stop_addr - hdr_start_addr} + LP_LEN_ONE;
                    r_addr     <= hdr_start_addr;
                    r_stop     <= hdr_stop_addr;
                    r_evt_ltc  <= hdr_evt_ltc;
                    r_trig_src <= hdr_trig_src;
                    r_cnst_run <= hdr_cnst_run;
                    r_pre_conf <= hdr_pre_conf;
                    r_state    <= S_DATA;
                end
                S_DATA: begin
                    if (w_issue) begin
                        r_addr   <= r_addr + LP_ADR_ONE;
                        r_remain <= r_remain - LP_LEN_ONE;
                        if (r_remain == LP_LEN_ONE) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_last_pop) begin
                        r_rd_ptr <= r_stop + LP_ADR_ONE;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Combinational pop so a queued header is taken on the very first idle cycle.
    assign hdr_rdreq    = (r_state == S_IDLE) && !hdr_empty && !rst;
    assign wvb_rd_addr  = r_addr;
    assign out_valid    = (r_count != 3'd0);
    assign out_data     = r_fifo_data[r_head];
    assign out_sof      = out_valid && r_fifo_sof[r_head];
    assign out_eof      = out_valid && r_fifo_eof[r_head];
    assign out_evt_len  = r_evt_len;
    assign out_evt_ltc  = r_evt_ltc;
    assign out_trig_src = r_trig_src;
    assign out_cnst_run = r_cnst_run;
    assign out_pre_conf = r_pre_conf;
    assign rd_ptr       = r_rd_ptr;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_wvb_rd_ctrl.sv
// Scoreboard bench for wvb_rd_ctrl: header FIFO and buffer RAM models, randomized events
// and backpressure, with a monitor comparing every accepted word against expected samples.
module tb_wvb_rd_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hdr_empty;
    logic        hdr_rdreq;
    logic [11:0] hdr_start_addr = '0;
    logic [11:0] hdr_stop_addr = '0;
    logic [47:0] hdr_evt_ltc = '0;
    logic [1:0]  hdr_trig_src = '0;
    logic        hdr_cnst_run = 1'b0;
    logic [4:0]  hdr_pre_conf = '0;
    logic [11:0] wvb_rd_addr;
    logic [21:0] wvb_rd_data = '0;
    logic [21:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sof;
    logic        out_eof;
    logic [12:0] out_evt_len;
    logic [47:0] out_evt_ltc;
    logic [1:0]  out_trig_src;
    logic        out_cnst_run;
    logic [4:0]  out_pre_conf;
    logic [11:0] rd_ptr;
    logic        busy;

    wvb_rd_ctrl dut (
        .clk(clk), .rst(rst), .hdr_empty(hdr_empty), .hdr_rdreq(hdr_rdreq),
        .hdr_start_addr(hdr_start_addr), .hdr_stop_addr(hdr_stop_addr),
        .hdr_evt_ltc(hdr_evt_ltc), .hdr_trig_src(hdr_trig_src),
        .hdr_cnst_run(hdr_cnst_run), .hdr_pre_conf(hdr_pre_conf),
        .wvb_rd_addr(wvb_rd_addr), .wvb_rd_data(wvb_rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .out_evt_len(out_evt_len),
        .out_evt_ltc(out_evt_ltc), .out_trig_src(out_trig_src),
        .out_cnst_run(out_cnst_run), .out_pre_conf(out_pre_conf),
        .rd_ptr(rd_ptr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] data;
        logic        sof;
        logic        eof;
        logic [12:0] len;
        logic [47:0] ltc;
        logic [1:0]  trig;
        logic        cnst;
        logic [4:0]  pre;
        logic [11:0] nptr;
    } exp_t;

    exp_t        sbq[$];
    logic [21:0] mem [4096];
    logic [11:0] hq_s [16];
    logic [11:0] hq_e [16];
    logic [47:0] hq_l [16];
    logic [1:0]  hq_t [16];
    logic        hq_c [16];
    logic [4:0]  hq_p [16];
    int          hq_wr = 0;
    int          hq_rd = 0;
    int          tests = 0;
    int          fails = 0;
    int          beats = 0;
    bit          rmode = 1'b0;

    assign hdr_empty = (hq_wr == hq_rd);

    always @(posedge clk) begin
        wvb_rd_data <= mem[wvb_rd_addr];
        if (hdr_rdreq) begin
            hdr_start_addr <= hq_s[hq_rd % 16];
            hdr_stop_addr  <= hq_e[hq_rd % 16];
            hdr_evt_ltc    <= hq_l[hq_rd % 16];
            hdr_trig_src   <= hq_t[hq_rd % 16];
            hdr_cnst_run   <= hq_c[hq_rd % 16];
            hdr_pre_conf   <= hq_p[hq_rd % 16];
            hq_rd          <= hq_rd + 1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected stream is the plain list of buffer samples from start to stop, wrapping mod 4096.
    task automatic push_hdr(input logic [11:0] s, input logic [11:0] e);
        exp_t x;
        int   len;
        int   k;
        k = hq_wr % 16;
        hq_s[k] = s;
        hq_e[k] = e;
        hq_l[k] = {16'($urandom), 32'($urandom)};
        hq_t[k] = 2'($urandom);
        hq_c[k] = 1'($urandom);
        hq_p[k] = 5'($urandom);
        len = ((int'(e) - int'(s) + 4096) % 4096) + 1;
        for (int i = 0; i < len; i++) begin
            x.data = mem[(int'(s) + i) % 4096];
            x.sof  = (i == 0);
            x.eof  = (i == len - 1);
            x.len  = 13'(len);
            x.ltc  = hq_l[k];
            x.trig = hq_t[k];
            x.cnst = hq_c[k];
            x.pre  = hq_p[k];
            x.nptr = 12'((int'(e) + 1) % 4096);
            sbq.push_back(x);
        end
        hq_wr = hq_wr + 1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (!(hdr_empty && sbq.size() == 0 && !busy) && n < limit) begin
            step(1);
            n++;
        end
        tests++;
        if (n >= limit) begin
            fails++;
            $display("FAIL %s: timeout, %0d words still expected", name, sbq.size());
        end
    endtask

    logic [11:0] exp_ptr = '0;
    logic [21:0] prev_data;
    logic        prev_sof;
    logic        prev_eof;
    bit          stall_prev = 1'b0;
    bit          eof_prev = 1'b0;
    bit          wait_first = 1'b0;
    bit          in_evt = 1'b0;
    bit          all_rdy = 1'b0;
    int          cyc = 0;
    int          rq_cyc = 0;
    int          sof_cyc = 0;

    always @(negedge clk) begin
        exp_t x;
        cyc++;
        if (rst) begin
            exp_ptr    = '0;
            stall_prev = 1'b0;
            eof_prev   = 1'b0;
            wait_first = 1'b0;
            in_evt     = 1'b0;
        end else begin
            chk("rd_ptr", 64'(rd_ptr), 64'(exp_ptr));
            if (hdr_empty) chk("rdreq_while_empty", 64'(hdr_rdreq), 64'd0);
            if (eof_prev && !hdr_empty) chk("rdreq_after_eof", 64'(hdr_rdreq), 64'd1);
            if (stall_prev)
                chk("stall_hold", {40'd0, out_valid, out_sof, out_eof, out_data},
                    {40'd0, 1'b1, prev_sof, prev_eof, prev_data});
            if (hdr_rdreq) begin
                rq_cyc     = cyc;
                wait_first = 1'b1;
            end
            if (out_valid && out_sof && wait_first) begin
                tests++;
                if (cyc - rq_cyc > 5) begin
                    fails++;
                    $display("FAIL first_word_latency: got %0d cycles required <= 5", cyc - rq_cyc);
                end
                wait_first = 1'b0;
            end
            if (in_evt && !out_ready) all_rdy = 1'b0;
            eof_prev = 1'b0;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h with nothing expected", out_data);
                end else begin
                    x = sbq.pop_front();
                    beats++;
                    chk("word", {40'd0, out_sof, out_eof, out_data}, {40'd0, x.sof, x.eof, x.data});
                    chk("meta", {out_evt_len, out_trig_src, out_cnst_run, out_pre_conf, out_evt_ltc[40:0]},
                        {x.len, x.trig, x.cnst, x.pre, x.ltc[40:0]});
                    chk("ltc_hi", 64'(out_evt_ltc[47:41]), 64'(x.ltc[47:41]));
                    if (x.sof) begin
                        sof_cyc = cyc;
                        all_rdy = 1'b1;
                        in_evt  = 1'b1;
                    end
                    if (x.eof) begin
                        if (all_rdy) chk("throughput", 64'(cyc - sof_cyc), 64'(int'(x.len) - 1));
                        in_evt   = 1'b0;
                        eof_prev = 1'b1;
                        exp_ptr  = x.nptr;
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_sof   = out_sof;
            prev_eof   = out_eof;
        end
    end

    task automatic chk_zero(input string name);
        chk(name, {out_valid, out_sof, out_eof, busy, hdr_rdreq, wvb_rd_addr, rd_ptr, out_data, 13'd0},
            64'd0);
        chk({name, "_meta"}, {out_evt_len, out_trig_src, out_cnst_run, out_pre_conf, 1'b0, out_evt_ltc[40:0]},
            64'd0);
        chk({name, "_ltc"}, 64'(out_evt_ltc[47:41]), 64'd0);
    endtask

    initial begin
        int b0;
        int n;
        logic [11:0] s;
        for (int i = 0; i < 4096; i++) mem[i] = 22'($urandom);
        step(3);
        hq_wr = 0;
        chk_zero("reset");
        rst = 1'b0;
        step(4);
        chk("idle_busy", 64'(busy), 64'd0);

        rmode = 1'b0;
        push_hdr(12'h010, 12'h013);
        wait_idle("ev_basic", 200);
        chk("ptr_basic", 64'(rd_ptr), 64'h014);
        push_hdr(12'hFFE, 12'h001);
        wait_idle("ev_wrap", 200);
        chk("ptr_wrap", 64'(rd_ptr), 64'h002);
        push_hdr(12'h100, 12'h100);
        wait_idle("ev_single", 200);
        chk("ptr_single", 64'(rd_ptr), 64'h101);

        rmode = 1'b1;
        push_hdr(12'h300, 12'h307);
        wait_idle("ev_backpressure", 400);
        chk("ptr_backpressure", 64'(rd_ptr), 64'h308);

        rmode = 1'b0;
        push_hdr(12'h000, 12'h002);
        push_hdr(12'h003, 12'h005);
        wait_idle("ev_back_to_back", 300);
        chk("ptr_back_to_back", 64'(rd_ptr), 64'h006);

        for (int ev = 0; ev < 30; ev++) begin
            rmode = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 3));
            for (int j = 0; j < n; j++) begin
                s = 12'($urandom);
                push_hdr(s, 12'(int'(s) + int'($urandom_range(0, 47))));
            end
            wait_idle("ev_random", 2000);
        end

        rmode = 1'b0;
        push_hdr(12'h123, 12'h122);
        wait_idle("ev_full_buffer", 6000);
        chk("ptr_full_buffer", 64'(rd_ptr), 64'h123);

        rmode = 1'b0;
        b0 = beats;
        push_hdr(12'h200, 12'h205);
        n = 0;
        while (beats < b0 + 2 && n < 100) begin
            step(1);
            n++;
        end
        chk("reset_event_progress", 64'(beats - b0), 64'd2);
        #1 rst = 1'b1;
        #1;
        chk_zero("mid_reset");
        sbq.delete();
        step(2);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (busy || out_valid) n++;
        end
        chk("post_reset_idle", 64'(n), 64'd0);
        push_hdr(12'h040, 12'h044);
        wait_idle("ev_after_reset", 200);
        chk("ptr_after_reset", 64'(rd_ptr), 64'h045);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wvb_rd_ctrl.md
WVB_RD_CTRL -- requirements
Module: wvb_rd_ctrl

Interface
REQ-001 Parameters SHALL be: P_DATA_WIDTH, default 22, waveform sample width; P_ADR_WIDTH, default 12, buffer address width; P_LTC_WIDTH, default 48, timestamp width; P_PRE_CONF_WIDTH, default 5, pretrigger config width.
REQ-002 Ports SHALL be (name direction width meaning):
 clk  in  1  single clock; all logic on rising edge.
 rst  in  1  asynchronous, active-high reset.
 hdr_empty  in  1  header FIFO empty.
 hdr_rdreq  out  1  header FIFO pop, one-cycle pulse; FIFO data valid the cycle after.
 hdr_start_addr  in  P_ADR_WIDTH  first sample address of event.
 hdr_stop_addr  in  P_ADR_WIDTH  last sample address of event (inclusive).
 hdr_evt_ltc  in  P_LTC_WIDTH  event timestamp.
 hdr_trig_src  in  2  trigger source.
 hdr_cnst_run  in  1  constant-run flag.
 hdr_pre_conf  in  P_PRE_CONF_WIDTH  pretrigger length.
 wvb_rd_addr  out  P_ADR_WIDTH  buffer RAM read address; RAM data valid one cycle after address.
 wvb_rd_data  in  P_DATA_WIDTH  buffer RAM read data.
 out_data  out  P_DATA_WIDTH  sample word.
 out_valid  out  1  out_data valid.
 out_ready  in  1  consumer accepts when out_valid && out_ready.
 out_sof  out  1  with out_valid: first sample of event.
 out_eof  out  1  with out_valid: last sample of event.
 out_evt_len  out  P_ADR_WIDTH+1  sample count of current event.
 out_evt_ltc  out  P_LTC_WIDTH  latched timestamp.
 out_trig_src  out  2  latched trigger source.
 out_cnst_run  out  1  latched flag.
 out_pre_conf  out  P_PRE_CONF_WIDTH  latched pretrigger length.
 rd_ptr  out  P_ADR_WIDTH  oldest unread address; writer uses it for overflow detection.
 busy  out  1  high in any state but S_IDLE.

Function
REQ-003 FSM SHALL have states S_IDLE, S_HDR_POP, S_HDR_LATCH, S_DATA, S_DRAIN.
REQ-004 S_IDLE: if !hdr_empty, SHALL assert hdr_rdreq for one cycle and go to S_HDR_POP; otherwise stay.
REQ-005 S_HDR_POP: SHALL wait one cycle for FIFO data, go to S_HDR_LATCH.
REQ-006 S_HDR_LATCH: SHALL latch all hdr_* fields, compute out_evt_len = ((stop - start) mod 2^P_ADR_WIDTH) + 1, set wvb_rd_addr = start, go to S_DATA.
REQ-007 out_evt_*, out_trig_src, out_cnst_run, out_pre_conf SHALL be stable from first out_sof beat through out_eof acceptance.
REQ-008 S_DATA: SHALL issue reads start..stop, incrementing wvb_rd_addr modulo 2^P_ADR_WIDTH (stop < start wraps through 0).
REQ-009 With out_ready held high, SHALL sustain one accepted word per cycle after first-word latency of at most 2 cycles from S_DATA entry.
REQ-010 Under arbitrary out_ready, no word SHALL be lost, duplicated or reordered; out_data/out_sof/out_eof SHALL hold while out_valid && !out_ready.
REQ-011 out_sof SHALL be high on exactly the first word, out_eof on exactly the last; both high on a 1-sample event (start == stop).
REQ-012 stop == start - 1 (mod) SHALL yield a full-buffer event of 2^P_ADR_WIDTH words, out_evt_len = 2^P_ADR_WIDTH.
REQ-013 After last read issued, SHALL go to S_DRAIN; on out_eof acceptance, rd_ptr SHALL become stop + 1 (mod) and FSM SHALL return to S_IDLE.
REQ-014 rd_ptr SHALL change only at REQ-013; never mid-event.
REQ-015 Back-to-back events: S_IDLE SHALL pop the next header on the cycle after out_eof acceptance if !hdr_empty.
REQ-016 hdr_rdreq SHALL never be asserted while hdr_empty is high, nor outside S_IDLE.

Reset
REQ-017 On rst, asynchronously: FSM = S_IDLE; hdr_rdreq, out_valid, out_sof, out_eof, busy = 0; wvb_rd_addr, rd_ptr, out_data, all out_* latched fields = 0; any skid storage emptied.
REQ-018 rst mid-event SHALL discard the partial event with no further out_valid; the pending header is not replayed.

Verification
REQ-019 Single event start=0x010, stop=0x013, out_ready=1 -> 4 words from addr 0x010..0x013, sof on 1st, eof on 4th, out_evt_len=4, rd_ptr=0x014.
REQ-020 Wrap: start=0xFFE, stop=0x001 -> addrs 0xFFE,0xFFF,0x000,0x001, out_evt_len=4, rd_ptr=0x002.
REQ-021 One-sample event start=stop=0x100 -> single word with sof=eof=1, out_evt_len=1, rd_ptr=0x101.
REQ-022 Backpressure: 8-word event, out_ready random 50% -> exactly 8 accepted words in address order, data stable during stalls.
REQ-023 Two queued headers (0x000-0x002, 0x003-0x005), out_ready=1 -> second hdr_rdreq the cycle after first eof accepted; 6 words total, rd_ptr=0x006.
REQ-024 rst asserted after 2nd word of a 6-word event -> out_valid=0 and all outputs zero immediately; after release, idle until hdr_empty=0.
